// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle control unit: instruction fields and
// memory/ALU status in, datapath strobes, mux selects and fault flags out.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               MemRdEn;
  logic               MemWrEn;
  logic               RegWrEn;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic               InvalidInst;
  logic               MemFault;
  logic [2:0]         State;

  modport master (
    input  OpCode, Funct, Zero, MemReady,
    output PCWrite, IRWrite, IorD, MemRdEn, MemWrEn, RegWrEn,
    output RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
    output InvalidInst, MemFault, State
  );

  modport slave (
    output OpCode, Funct, Zero, MemReady,
    input  PCWrite, IRWrite, IorD, MemRdEn, MemWrEn, RegWrEn,
    input  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
    input  InvalidInst, MemFault, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM with memory wait timeout and sticky fault flags.
// state  | meaning
// FETCH  | read instruction, PC+4; waits on MemReady
// DECODE | branch target into ALUOut, legality check
// EXEC   | ALU op / branch / jump
// MEM    | lw/sw data access; waits on MemReady
// WB     | register file write
// FAULT  | absorbing until reset
module multicycle_control_unit #(
  parameter int ALUOP_W    = 4,
  parameter int WAIT_LIMIT = 8
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd1);
  localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(4'hF);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  function automatic logic [3:0] r_aluop(input logic [5:0] fn);
    case (fn)
      6'h20:   r_aluop = 4'd0;
      6'h22:   r_aluop = 4'd1;
      6'h24:   r_aluop = 4'd2;
      6'h25:   r_aluop = 4'd3;
      6'h2A:   r_aluop = 4'd4;
      6'h26:   r_aluop = 4'd5;
      6'h27:   r_aluop = 4'd6;
      6'h00:   r_aluop = 4'd7;
      6'h02:   r_aluop = 4'd8;
      6'h29:   r_aluop = 4'd9;
      default: r_aluop = 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] i_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LW, OP_SW: i_aluop = 4'd0;
      OP_ANDI:               i_aluop = 4'd2;
      OP_ORI:                i_aluop = 4'd3;
      OP_SLTI:               i_aluop = 4'd4;
      OP_XORI:               i_aluop = 4'd5;
      default:               i_aluop = 4'hF;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                inv_q, inv_d;
  logic                mflt_q, mflt_d;

  logic                pc_write, ir_write, iord, mem_rd, mem_wr, reg_wr;
  logic [1:0]          reg_dst, mem_to_reg, src_a, src_b, pc_src;
  logic [ALUOP_W-1:0]  alu_op;

  logic is_r, is_jr, is_shift, is_imm, is_lw, is_sw, is_br, is_jmp, legal;
  logic wait_expired;

  assign is_r     = (bus.OpCode == OP_R);
  assign is_jr    = is_r && (bus.Funct == FN_JR);
  assign is_shift = is_r && ((bus.Funct == FN_SLL) || (bus.Funct == FN_SRL));
  assign is_imm   = (bus.OpCode == OP_ADDI) || (bus.OpCode == OP_ANDI) || (bus.OpCode == OP_ORI) ||
                    (bus.OpCode == OP_XORI) || (bus.OpCode == OP_SLTI);
  assign is_lw    = (bus.OpCode == OP_LW);
  assign is_sw    = (bus.OpCode == OP_SW);
  assign is_br    = (bus.OpCode == OP_BEQ) || (bus.OpCode == OP_BNE);
  assign is_jmp   = (bus.OpCode == OP_J) || (bus.OpCode == OP_JAL);
  assign legal    = (is_r && (is_jr || (r_aluop(bus.Funct) != 4'hF))) ||
                    is_imm || is_lw || is_sw || is_br || is_jmp;
  // Counter equal to the limit with MemReady still low means the access has timed out.
  assign wait_expired = (wait_q == WAIT_W'(WAIT_LIMIT));

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    inv_d      = inv_q;
    mflt_d     = mflt_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    src_a      = 2'd0;
    src_b      = 2'd0;
    pc_src     = 2'd0;
    alu_op     = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        src_b  = 2'd1;
        alu_op = ALU_ADD;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
          mflt_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        src_b  = 2'd3;
        alu_op = ALU_ADD;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FAULT;
          inv_d   = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_jr) begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
        end else if (is_r) begin
          src_a   = is_shift ? 2'd2 : 2'd1;
          alu_op  = ALUOP_W'(r_aluop(bus.Funct));
          state_d = S_WB;
        end else if (is_imm || is_lw || is_sw) begin
          src_a   = 2'd1;
          src_b   = 2'd2;
          alu_op  = ALUOP_W'(i_aluop(bus.OpCode));
          state_d = (is_lw || is_sw) ? S_MEM : S_WB;
        end else if (is_br) begin
          src_a    = 2'd1;
          alu_op   = ALU_SUB;
          pc_src   = 2'd1;
          pc_write = (bus.OpCode == OP_BEQ) ? bus.Zero : !bus.Zero;
        end else if (is_jmp) begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
          if (bus.OpCode == OP_JAL) begin
            reg_wr     = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (bus.MemReady) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_FAULT;
          mflt_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r ? 2'd1 : 2'd0;
        mem_to_reg = is_lw ? 2'd1 : 2'd0;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      inv_q   <= 1'b0;
      mflt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      inv_q   <= inv_d;
      mflt_q  <= mflt_d;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.IorD        = iord;
  assign bus.MemRdEn     = mem_rd;
  assign bus.MemWrEn     = mem_wr;
  assign bus.RegWrEn     = reg_wr;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.PCSrc       = pc_src;
  assign bus.ALUOp       = alu_op;
  assign bus.InvalidInst = inv_q;
  assign bus.MemFault    = mflt_q;
  assign bus.State       = state_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUOP_W, default 4, ALUOp width; SHALL be at least 4.
REQ-002 Parameter WAIT_LIMIT, default 8, maximum cycles a memory access may wait for MemReady before a fault.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 OpCode, Funct  in  6 each  fields from the external instruction register.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 MemReady  in  1  memory completes the current access in this cycle.
REQ-008 PCWrite, IRWrite, IorD, MemRdEn, MemWrEn, RegWrEn  out  1 each  datapath strobes and selects.
REQ-009 RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc  out  2 each  datapath mux selects.
REQ-010 ALUOp  out  ALUOP_W  ALU operation code.
REQ-011 InvalidInst, MemFault  out  1 each  sticky fault flags.
REQ-012 State  out  3  current FSM state, for debug.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7, with all outputs decoded from the registered state plus OpCode/Funct.
REQ-014 Every output is 0 unless stated otherwise; ALUOp defaults to 4'b1111 (nop), zero-extended to ALUOP_W.
REQ-015 ALUOp codes: add 0, sub 1, and 2, or 3, slt 4, xor 5, nor 6, sll 7, srl 8, sgt 9.
REQ-016 Select encodings:
- RegDst: 0 rt, 1 rd, 2 $31.
- MemtoReg: 0 ALUOut, 1 MDR, 2 PC.
- ALUSrcA: 0 PC, 1 rs, 2 shamt.
- ALUSrcB: 0 rt, 1 constant 4, 2 sign-extended imm, 3 imm<<2.
- PCSrc: 0 ALU result, 1 ALUOut, 2 jump target, 3 rs.
REQ-017 FETCH: MemRdEn=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1, which advances to DECODE; otherwise remain in FETCH.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target into ALUOut).
- Legal opcodes advance to EXEC.
- Illegal opcodes and illegal R-type functs go to FAULT and set InvalidInst.
REQ-019 Legal set:
- R-type (opcode 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sgt 0x29, sll 0x00, srl 0x02, jr 0x08.
- addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
REQ-020 EXEC, R-type: ALUSrcA=1 (2 for sll/srl), ALUSrcB=0, funct ALUOp, then WB.
REQ-021 EXEC, immediates and lw/sw: ALUSrcA=1, ALUSrcB=2, ALUOp per opcode (lw/sw add); immediates go to WB, lw/sw go to MEM.
REQ-022 EXEC, beq/bne: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSrc=1, PCWrite=Zero (beq) or !Zero (bne); then FETCH.
REQ-023 EXEC, j: PCSrc=2, PCWrite=1, then FETCH.
REQ-024 EXEC, jal: as j, plus RegWrEn=1, RegDst=2, MemtoReg=2; then FETCH.
REQ-025 EXEC, jr: PCSrc=3, PCWrite=1, then FETCH.
REQ-026 MEM: IorD=1; MemRdEn=1 for lw, MemWrEn=1 for sw; hold until MemReady=1.
- Then lw goes to WB and sw goes to FETCH.
REQ-027 WB: RegWrEn=1; R-type RegDst=1, MemtoReg=0; immediates RegDst=0, MemtoReg=0; lw RegDst=0, MemtoReg=1; then FETCH.
REQ-028 Cycle counts with zero wait: branch/j/jal/jr 3, R-type/immediate/sw 4, lw 5.
REQ-029 Wait counter:
- Counts consecutive cycles in FETCH or MEM with MemReady=0.
- Clears on MemReady=1 and on any state change.
- Width is clog2(WAIT_LIMIT+1).
- When it equals WAIT_LIMIT with MemReady still 0, the next state is FAULT and MemFault is set.
REQ-030 MemReady=1 in the same cycle the counter reaches WAIT_LIMIT SHALL complete the access normally, with no fault.
REQ-031 FAULT is absorbing: all strobes 0 and the fault flags held until reset.

Reset
REQ-032 reset=1 SHALL immediately force State=FETCH, clear the wait counter, and clear InvalidInst and MemFault, including mid-access or in FAULT.
REQ-033 In the first cycle after reset deasserts, the block SHALL issue a FETCH read.

Verification
REQ-034 add (0x00/0x20), MemReady always 1 -> states 0,1,2,4,0; ALUOp=0 in EXEC; RegWrEn=1, RegDst=1 in WB.
REQ-035 lw with MemReady low 3 cycles in MEM -> stays in state 3 for 4 cycles; WB has MemtoReg=1, RegWrEn=1.
REQ-036 beq with Zero=1 and then Zero=0 -> PCWrite=1 and PCWrite=0 respectively in EXEC, PCSrc=1, 3 cycles each.
REQ-037 jal -> EXEC has PCWrite=1, PCSrc=2, RegWrEn=1, RegDst=2, MemtoReg=2.
REQ-038 MemReady held 0 in FETCH with WAIT_LIMIT=8 -> FAULT after 9 cycles with MemFault=1; a separate run with MemReady=1 on the 9th cycle -> DECODE, no fault.
REQ-039 Opcode 0x3F -> FAULT, InvalidInst=1 held; reset pulse -> FETCH, flags cleared.
